// File: rtl/mem_wb_multi_if.sv
// rtl/mem_wb_multi_if.sv - MEM/WB stage bundle: stall/flush controls, MEM capture side, WB presentation side
interface mem_wb_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 2,
  parameter int CNT_W  = 32
);
  logic [5:0]              stall;
  logic                    flush;
  logic                    cnt_clr;
  logic [LANES-1:0]        mem_valid;
  logic [LANES-1:0]        mem_wreg;
  logic [LANES*ADDR_W-1:0] mem_wd;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic                    mem_whilo;
  logic [DATA_W-1:0]       mem_hi;
  logic [DATA_W-1:0]       mem_lo;
  logic [LANES-1:0]        wb_valid;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic                    wb_whilo;
  logic [DATA_W-1:0]       wb_hi;
  logic [DATA_W-1:0]       wb_lo;
  logic [CNT_W-1:0]        retired_cnt;

  modport master (
    output stall, flush, cnt_clr, mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, retired_cnt
  );

  modport slave (
    input  stall, flush, cnt_clr, mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, retired_cnt
  );
endinterface

// File: rtl/mem_wb_multi.sv
// rtl/mem_wb_multi.sv - multi-lane MEM/WB pipeline register with collision resolution and retired counter
module mem_wb_multi #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LANES     = 2,
  parameter int STALL_IDX = 4,
  parameter int CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_multi_if.slave bus
);
  logic             advance;
  logic             bubble;
  logic [LANES-1:0] wreg_base;
  logic [LANES-1:0] wreg_res;
  logic [2:0]       pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_stall_bits;

  // Only this stage and the next one matter; the other stall bits are deliberately ignored.
  assign advance           = ~bus.stall[STALL_IDX];
  assign bubble            = bus.stall[STALL_IDX] & ~bus.stall[STALL_IDX+1];
  assign unused_stall_bits = ^bus.stall;

  // r0 writes are dropped, then an older lane yields to any younger lane writing the same register.
  always_comb begin
    wreg_base = '0;
    for (int i = 0; i < LANES; i++)
      wreg_base[i] = bus.mem_valid[i] & bus.mem_wreg[i] & (bus.mem_wd[i*ADDR_W +: ADDR_W] != '0);
    wreg_res = wreg_base;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (wreg_base[j] && (bus.mem_wd[j*ADDR_W +: ADDR_W] == bus.mem_wd[i*ADDR_W +: ADDR_W]))
          wreg_res[i] = 1'b0;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++)
      pop = pop + {2'b00, bus.mem_valid[i]};
  end

  // One extra sum bit detects overflow so the counter pins at all-ones instead of wrapping.
  assign cnt_sum  = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, pop};
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  assign bus.retired_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_valid <= '0;
      bus.wb_wreg  <= '0;
      bus.wb_wd    <= '0;
      bus.wb_wdata <= '0;
      bus.wb_whilo <= 1'b0;
      bus.wb_hi    <= '0;
      bus.wb_lo    <= '0;
      cnt_q        <= '0;
    end else begin
      if (bus.flush || bubble) begin
        bus.wb_valid <= '0;
        bus.wb_wreg  <= '0;
        bus.wb_wd    <= '0;
        bus.wb_wdata <= '0;
        bus.wb_whilo <= 1'b0;
        bus.wb_hi    <= '0;
        bus.wb_lo    <= '0;
      end else if (advance) begin
        bus.wb_valid <= bus.mem_valid;
        bus.wb_wreg  <= wreg_res;
        bus.wb_wd    <= bus.mem_wd;
        bus.wb_wdata <= bus.mem_wdata;
        bus.wb_whilo <= bus.mem_whilo & (|bus.mem_valid);
        bus.wb_hi    <= bus.mem_hi;
        bus.wb_lo    <= bus.mem_lo;
      end
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (advance && !bus.flush)
        cnt_q <= cnt_next;
    end
  end
endmodule

// File: tb/tb_mem_wb_multi.sv
// tb/tb_mem_wb_multi.sv - scoreboard bench for mem_wb_multi with 32-bit and 4-bit counter instances
module tb_mem_wb_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [1:0]  valid = '0;
  logic [1:0]  wreg = '0;
  logic [9:0]  wd = '0;
  logic [63:0] wdata = '0;
  logic        whilo = 1'b0;
  logic [31:0] hi = '0;
  logic [31:0] lo = '0;

  always #5 clk = ~clk;

  mem_wb_multi_if #(.DATA_W(32), .ADDR_W(5), .LANES(2), .CNT_W(32)) i0 ();
  mem_wb_multi_if #(.DATA_W(32), .ADDR_W(5), .LANES(2), .CNT_W(4))  i1 ();

  assign i0.stall = stall;  assign i0.flush = flush;  assign i0.cnt_clr = cnt_clr;
  assign i0.mem_valid = valid;  assign i0.mem_wreg = wreg;  assign i0.mem_wd = wd;
  assign i0.mem_wdata = wdata;  assign i0.mem_whilo = whilo;  assign i0.mem_hi = hi;
  assign i0.mem_lo = lo;
  assign i1.stall = stall;  assign i1.flush = flush;  assign i1.cnt_clr = cnt_clr;
  assign i1.mem_valid = valid;  assign i1.mem_wreg = wreg;  assign i1.mem_wd = wd;
  assign i1.mem_wdata = wdata;  assign i1.mem_whilo = whilo;  assign i1.mem_hi = hi;
  assign i1.mem_lo = lo;

  mem_wb_multi #(.DATA_W(32), .ADDR_W(5), .LANES(2), .STALL_IDX(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(i0.slave));
  mem_wb_multi #(.DATA_W(32), .ADDR_W(5), .LANES(2), .STALL_IDX(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(i1.slave));

  typedef struct {
    logic [142:0] b;
    logic [31:0]  c32;
    logic [3:0]   c4;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  logic [142:0] act;

  // Drive one cycle's MEM inputs just after the negedge; they are captured at the following posedge.
  task automatic drive(input logic r, input logic [5:0] s, input logic f, input logic c,
                       input logic [1:0] v, input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a0,
                       input logic [31:0] d1, input logic [31:0] d0, input logic wh,
                       input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    #1;
    rst = r; stall = s; flush = f; cnt_clr = c;
    valid = v; wreg = w; wd = {a1, a0}; wdata = {d1, d0};
    whilo = wh; hi = h; lo = l;
  endtask

  task automatic exp_bundle(input logic [1:0] v, input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a0,
                            input logic [31:0] d1, input logic [31:0] d0, input logic wh,
                            input logic [31:0] h, input logic [31:0] l,
                            input logic [31:0] c32, input logic [3:0] c4);
    exp_t x;
    x.b = {v, w, a1, a0, d1, d0, wh, h, l};
    x.c32 = c32;
    x.c4 = c4;
    q.push_back(x);
  endtask

  task automatic exp_bubble(input logic [31:0] c32, input logic [3:0] c4);
    exp_bundle(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, c32, c4);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {i0.wb_valid, i0.wb_wreg, i0.wb_wd, i0.wb_wdata, i0.wb_whilo, i0.wb_hi, i0.wb_lo};
      n_cmp++;
      if (act !== e.b) begin
        n_bad++;
        $display("FAIL wb_bundle t=%0t actual=%h required=%h", $time, act, e.b);
      end
      n_cmp++;
      if (i0.retired_cnt !== e.c32) begin
        n_bad++;
        $display("FAIL retired_cnt32 t=%0t actual=%0d required=%0d", $time, i0.retired_cnt, e.c32);
      end
      n_cmp++;
      if (i1.retired_cnt !== e.c4) begin
        n_bad++;
        $display("FAIL retired_cnt4 t=%0t actual=%0d required=%0d", $time, i1.retired_cnt, e.c4);
      end
    end
  end

  initial begin
    // reset dominates busy inputs, including a HOLD stall pattern
    drive(1, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd3, 5'd4, 32'h1234, 32'h5678, 1, 32'hFFFF, 32'hEEEE);
    exp_bubble(0, 0);
    drive(1, 6'b110000, 0, 0, 2'b11, 2'b11, 5'd3, 5'd4, 32'h1234, 32'h5678, 1, 32'hFFFF, 32'hEEEE);
    exp_bubble(0, 0);

    // plain two-lane advance
    drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd7, 5'd5, 32'hBBBB, 32'hAAAA, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b11, 5'd7, 5'd5, 32'hBBBB, 32'hAAAA, 0, 32'h0, 32'h0, 2, 2);

    // same-address collision: younger lane 1 keeps the write
    drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd9, 5'd9, 32'h2222, 32'h1111, 1, 32'hA1, 32'hB1);
    exp_bundle(2'b11, 2'b10, 5'd9, 5'd9, 32'h2222, 32'h1111, 1, 32'hA1, 32'hB1, 4, 4);
    // r0 write on lane 0 suppressed
    drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd3, 5'd0, 32'h4444, 32'h3333, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b10, 5'd3, 5'd0, 32'h4444, 32'h3333, 0, 32'h0, 32'h0, 6, 6);
    // invalid lane 1 cannot win a collision
    drive(0, 6'b000000, 0, 0, 2'b01, 2'b11, 5'd12, 5'd12, 32'h6666, 32'h5555, 1, 32'hC1, 32'hD1);
    exp_bundle(2'b01, 2'b01, 5'd12, 5'd12, 32'h6666, 32'h5555, 1, 32'hC1, 32'hD1, 7, 7);
    // no valid lanes: HI/LO write dropped, data still captured raw
    drive(0, 6'b000000, 0, 0, 2'b00, 2'b11, 5'd13, 5'd14, 32'h8888, 32'h7777, 1, 32'hE1, 32'hF1);
    exp_bundle(2'b00, 2'b00, 5'd13, 5'd14, 32'h8888, 32'h7777, 0, 32'hE1, 32'hF1, 7, 7);

    // bubble
    drive(0, 6'b010000, 0, 0, 2'b11, 2'b11, 5'd1, 5'd1, 32'h9999, 32'h9999, 1, 32'h1, 32'h1);
    exp_bubble(7, 7);
    drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd1, 5'd2, 32'h6, 32'h5, 1, 32'h12, 32'h34);
    exp_bundle(2'b11, 2'b11, 5'd1, 5'd2, 32'h6, 32'h5, 1, 32'h12, 32'h34, 9, 9);
    for (int k = 0; k < 3; k++) begin
      drive(0, 6'b110000, 0, 0, 2'b11, 2'b11, 5'd20, 5'd21, 32'hAB, 32'hCD, 0, 32'h0, 32'h0);
      exp_bundle(2'b11, 2'b11, 5'd1, 5'd2, 32'h6, 32'h5, 1, 32'h12, 32'h34, 9, 9);
    end
    drive(0, 6'b000000, 0, 0, 2'b10, 2'b10, 5'd17, 5'd0, 32'h77, 32'h66, 0, 32'h0, 32'h0);
    exp_bundle(2'b10, 2'b10, 5'd17, 5'd0, 32'h77, 32'h66, 0, 32'h0, 32'h0, 10, 10);
    // stall bits of other stages have no effect
    drive(0, 6'b001111, 0, 0, 2'b11, 2'b01, 5'd8, 5'd8, 32'h88, 32'h99, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b01, 5'd8, 5'd8, 32'h88, 32'h99, 0, 32'h0, 32'h0, 12, 12);

    // flush on advance, then flush during hold
    drive(0, 6'b000000, 1, 0, 2'b11, 2'b11, 5'd4, 5'd5, 32'h1, 32'h2, 1, 32'h3, 32'h4);
    exp_bubble(12, 12);
    drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd10, 5'd11, 32'hA, 32'hB, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b11, 5'd10, 5'd11, 32'hA, 32'hB, 0, 32'h0, 32'h0, 14, 14);
    drive(0, 6'b110000, 0, 0, 2'b11, 2'b11, 5'd30, 5'd31, 32'h5, 32'h6, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b11, 5'd10, 5'd11, 32'hA, 32'hB, 0, 32'h0, 32'h0, 14, 14);
    drive(0, 6'b110000, 1, 0, 2'b11, 2'b11, 5'd30, 5'd31, 32'h5, 32'h6, 0, 32'h0, 32'h0);
    exp_bubble(14, 14);
    // counter clear while holding
    drive(0, 6'b110000, 0, 1, 2'b11, 2'b11, 5'd30, 5'd31, 32'h5, 32'h6, 0, 32'h0, 32'h0);
    exp_bubble(0, 0);

    // saturation of the 4-bit counter
    for (int k = 1; k <= 9; k++) begin
      drive(0, 6'b000000, 0, 0, 2'b11, 2'b11, 5'd1, 5'd2, 32'(k), 32'(k), 0, 32'h0, 32'h0);
      exp_bundle(2'b11, 2'b11, 5'd1, 5'd2, 32'(k), 32'(k), 0, 32'h0, 32'h0,
                 32'(2 * k), (2 * k > 15) ? 4'd15 : 4'(2 * k));
    end
    drive(0, 6'b000000, 0, 1, 2'b11, 2'b11, 5'd1, 5'd2, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    exp_bundle(2'b11, 2'b11, 5'd1, 5'd2, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    drive(0, 6'b000000, 0, 0, 2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    exp_bundle(2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
